shift_left_4bit_loader: RTL and testbench

Serial operand loader that sits directly upstream of `shift_left_4bit`. Assembles a 6-bit serial frame (4-bit data word plus 2-bit shift amount, MSB first) into parallel operands. Holds them stable on `in_o`/`n_o` (wired to the shifter's `in`/`n`) under a valid/ready handshake. Flags aborted frames and overruns, and counts delivered operand pairs.

---
 rtl/shift_left_4bit_loader_if.sv | 29 ++
 rtl/shift_left_4bit_loader.sv | 102 ++++++++++
 tb/tb_shift_left_4bit_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_4bit_loader_if.sv
// Operand-loader bus: serial frame input, parallel operand output with valid/ready, status flags.
// The loader uses the slave view and the upstream/downstream side uses the master view.
interface shift_left_4bit_loader_if #(
   parameter int DATA_W  = 4,
   parameter int SHAMT_W = 2,
   parameter int CNT_W   = 8
) ();
   logic               sdi;
   logic               sdi_valid;
   logic               sof;
   logic [DATA_W-1:0]  in_o;
   logic [SHAMT_W-1:0] n_o;
   logic               op_valid;
   logic               op_ready;
   logic               busy;
   logic               frame_err;
   logic               ovr_err;
   logic [CNT_W-1:0]   frame_cnt;

   modport master (
      output sdi, sdi_valid, sof, op_ready,
      input  in_o, n_o, op_valid, busy, frame_err, ovr_err, frame_cnt
   );

   modport slave (
      input  sdi, sdi_valid, sof, op_ready,
      output in_o, n_o, op_valid, busy, frame_err, ovr_err, frame_cnt
   );
endinterface

// File: rtl/shift_left_4bit_loader.sv
// Serial-to-parallel operand loader for shift_left_4bit: 6-bit MSB-first frames, operands valid F cycles after sof.
// Operands stay frozen while op_valid is high until op_ready; bits arriving meanwhile are dropped and flagged.
module shift_left_4bit_loader #(
   parameter int DATA_W  = 4,
   parameter int SHAMT_W = 2,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_left_4bit_loader_if.slave bus
);
   localparam int F  = DATA_W + SHAMT_W;
   localparam int CW = $clog2(F + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state_q;
   logic [F-1:0]     sr_q;
   logic [CW-1:0]    cnt_q;
   logic             op_valid_q;
   logic             busy_q;
   logic             frame_err_q;
   logic             ovr_err_q;
   logic [CNT_W-1:0] frame_cnt_q;

   logic         new_frame;
   logic [F-1:0] first_sr;

   assign new_frame = bus.sdi_valid & bus.sof;
   // A new frame clears stale bits so a restarted frame never mixes with the aborted one.
   assign first_sr  = F'(bus.sdi);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         op_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         ovr_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         frame_err_q <= 1'b0;
         ovr_err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (new_frame) begin
                  sr_q    <= first_sr;
                  cnt_q   <= CW'(1);
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.sdi_valid) begin
                  if (bus.sof) begin
                     frame_err_q <= 1'b1;
                     sr_q        <= first_sr;
                     cnt_q       <= CW'(1);
                  end else begin
                     sr_q  <= {sr_q[F-2:0], bus.sdi};
                     cnt_q <= cnt_q + CW'(1);
                     if (cnt_q == CW'(F - 1)) begin
                        state_q    <= HOLD;
                        op_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                     end
                  end
               end
            end
            HOLD: begin
               if (bus.op_ready) begin
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                  op_valid_q  <= 1'b0;
                  // A sof in the handshake cycle starts the next frame with no bubble.
                  if (new_frame) begin
                     sr_q    <= first_sr;
                     cnt_q   <= CW'(1);
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end
               end else if (bus.sdi_valid) begin
                  ovr_err_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_o      = sr_q[F-1:SHAMT_W];
   assign bus.n_o       = sr_q[SHAMT_W-1:0];
   assign bus.op_valid  = op_valid_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
   assign bus.ovr_err   = ovr_err_q;
   assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_shift_left_4bit_loader.sv
// Bench for shift_left_4bit_loader: directed frames with literal expectations, then random traffic
// checked every cycle against a queue-based frame model.
module tb_shift_left_4bit_loader;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   shift_left_4bit_loader_if #(.DATA_W(4), .SHAMT_W(2), .CNT_W(8)) bus ();

   shift_left_4bit_loader #(.DATA_W(4), .SHAMT_W(2), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] shl(input logic [3:0] a, input logic [1:0] n);
      return a << n;
   endfunction

   // Frame model: collected bits in a queue, a held 6-bit word, a handshake count.
   logic       m_bits[$];
   bit         m_hold = 1'b0;
   logic [5:0] m_word = '0;
   logic [7:0] m_cnt  = '0;
   bit         m_ferr = 1'b0;
   bit         m_ovr  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits.delete();
         m_hold = 1'b0;
         m_word = '0;
         m_cnt  = '0;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         if (m_hold) begin
            if (bus.op_ready) begin
               m_hold = 1'b0;
               m_cnt  = m_cnt + 8'd1;
               if (bus.sdi_valid && bus.sof) m_bits = {bus.sdi};
            end else if (bus.sdi_valid) begin
               m_ovr = 1'b1;
            end
         end else if (m_bits.size() != 0) begin
            if (bus.sdi_valid) begin
               if (bus.sof) begin
                  m_ferr = 1'b1;
                  m_bits = {bus.sdi};
               end else begin
                  m_bits.push_back(bus.sdi);
               end
               if (m_bits.size() == 6) begin
                  m_word = '0;
                  foreach (m_bits[i]) m_word = 6'(m_word * 2 + 6'(m_bits[i]));
                  m_hold = 1'b1;
                  m_bits.delete();
               end
            end
         end else if (bus.sdi_valid && bus.sof) begin
            m_bits = {bus.sdi};
         end
      end
   end

   always @(negedge clk) begin
      check("op_valid", 32'(bus.op_valid), 32'(m_hold));
      check("busy", 32'(bus.busy), 32'(m_bits.size() != 0));
      check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      check("ovr_err", 32'(bus.ovr_err), 32'(m_ovr));
      check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
      if (m_hold || !rst_n) begin
         check("in_o", 32'(bus.in_o), 32'(m_word / 4));
         check("n_o", 32'(bus.n_o), 32'(m_word % 4));
      end
   end

   task automatic drive(input logic v, input logic s, input logic d, input logic r);
      bus.sdi_valid = v;
      bus.sof       = s;
      bus.sdi       = d;
      bus.op_ready  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [5:0] w, input logic r);
      for (int i = 5; i >= 0; i--) drive(1'b1, i == 5, w[i], r);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.sdi = 1'b0; bus.sdi_valid = 1'b0; bus.sof = 1'b0; bus.op_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst in_o", 32'(bus.in_o), 0);
      check("rst op_valid", 32'(bus.op_valid), 0);
      check("rst frame_cnt", 32'(bus.frame_cnt), 0);
      rst_n = 1'b1;

      // Basic frame, consumer always ready
      send_frame(6'b110001, 1'b1);
      check("f1 op_valid", 32'(bus.op_valid), 1);
      check("f1 in_o", 32'(bus.in_o), 32'hC);
      check("f1 n_o", 32'(bus.n_o), 1);
      check("f1 shifter", 32'(shl(bus.in_o, bus.n_o)), 32'h8);
      check("f1 cnt before", 32'(bus.frame_cnt), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("f1 op_valid drop", 32'(bus.op_valid), 0);
      check("f1 cnt", 32'(bus.frame_cnt), 1);

      // Gaps mid-frame, long hold, overrun while holding
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("gap busy", 32'(bus.busy), 1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         check("hold op_valid", 32'(bus.op_valid), 1);
         check("hold in_o", 32'(bus.in_o), 32'hC);
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("ovr pulse", 32'(bus.ovr_err), 1);
      check("ovr in_o", 32'(bus.in_o), 32'hC);
      check("ovr n_o", 32'(bus.n_o), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr end", 32'(bus.ovr_err), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("f2 cnt", 32'(bus.frame_cnt), 2);

      // Aborted frame
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort frame_err", 32'(bus.frame_err), 1);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("abort pulse end", 32'(bus.frame_err), 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("abort in_o", 32'(bus.in_o), 32'hC);
      check("abort n_o", 32'(bus.n_o), 3);
      check("abort shifter", 32'(shl(bus.in_o, bus.n_o)), 0);

      // Back-to-back: next sof in the handshake cycle
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check("b2b ovr", 32'(bus.ovr_err), 0);
      check("b2b busy", 32'(bus.busy), 1);
      check("b2b cnt", 32'(bus.frame_cnt), 3);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("b2b op_valid", 32'(bus.op_valid), 1);
      check("b2b in_o", 32'(bus.in_o), 32'hB);
      check("b2b shifter", 32'(shl(bus.in_o, bus.n_o)), 32'hC);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("b2b cnt2", 32'(bus.frame_cnt), 4);

      // Reset mid-frame
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("mid in_o", 32'(bus.in_o), 32'h2);
      rst_n = 1'b0;
      #1;
      check("arst in_o", 32'(bus.in_o), 0);
      check("arst n_o", 32'(bus.n_o), 0);
      check("arst busy", 32'(bus.busy), 0);
      check("arst frame_cnt", 32'(bus.frame_cnt), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0);
      check("post rst busy", 32'(bus.busy), 0);
      send_frame(6'b011010, 1'b0);
      check("post rst in_o", 32'(bus.in_o), 32'h6);
      check("post rst n_o", 32'(bus.n_o), 2);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("post rst cnt", 32'(bus.frame_cnt), 1);

      // Counter wrap
      for (int i = 0; i < 254; i++) begin
         send_frame(6'($urandom), 1'b1);
         drive(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("cnt 255", 32'(bus.frame_cnt), 255);
      send_frame(6'($urandom), 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("cnt wrap", 32'(bus.frame_cnt), 0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) < 3),
               1'($urandom), 1'($urandom_range(0, 9) < 4));
         rst_n = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
